// File: rtl/mem_pkg.sv
// Shared encodings, tracker entry layout and byte-lane helpers
// for the EXE/MEM data-memory path.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic        is_load;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  addr;
    logic        done;
    logic        cancelled;
    logic [31:0] rdata;
  } mem_ent_t;

  function automatic logic [3:0] wstrb_gen(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      SZ_B:    s = 4'b0001 << a;
      SZ_H:    s = a[1] ? 4'b1100 : 4'b0011;
      SZ_W:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] wdata_rep(
    input logic [1:0]  size,
    input logic [31:0] d
  );
    logic [31:0] r;
    case (size)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [1:0]  size,
    input logic        uns,
    input logic [1:0]  a,
    input logic [31:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (size)
      SZ_B:    r = {{24{b[7] & ~uns}}, b};
      SZ_H:    r = {{16{h[15] & ~uns}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_ext_unit.sv
// Sign/zero extension of raw load data by size, signedness
// and byte offset; shared with the MEM stage.
module load_ext_unit
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  assign data_o = load_ext(size_i, unsigned_i, addr_i, rdata_i);

endmodule

// File: rtl/mem_req_tracker.sv
// In-order tracker for outstanding sram-like data requests with
// flush cancellation and a backpressured response port.
module mem_req_tracker
  import mem_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_kill,
  output logic              req_ready,
  output logic              req_ale,
  input  logic              flush,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_is_store,
  output logic [31:0]       resp_rdata,
  output logic              busy,
  output logic              proto_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  mem_ent_t      ent_q [DEPTH];
  mem_ent_t      ent_d [DEPTH];
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] ret_q, ret_d;
  logic [PW-1:0] dlv_q, dlv_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          perr_q, perr_d;

  logic          is_mem, full;
  logic          alloc, cpl, retire;
  logic          head_live;
  mem_ent_t      head;
  logic [31:0]   ext_data;

  assign is_mem = req_load | req_store;
  assign full   = (count_q == CW'(DEPTH));

  assign req_ale = req_valid & is_mem &
    (((req_size == SZ_W) & (req_addr[1:0] != 2'b00)) |
     ((req_size == SZ_H) & req_addr[0]));

  assign data_sram_req = req_valid & is_mem & ~req_ale &
                         ~req_kill & ~flush & ~full;
  assign data_sram_wr    = data_sram_req & req_store;
  assign data_sram_size  = req_size;
  assign data_sram_addr  = req_addr;
  assign data_sram_wstrb = req_store ?
    wstrb_gen(req_size, req_addr[1:0]) : 4'b0000;
  assign data_sram_wdata = wdata_rep(req_size, req_wdata);

  assign req_ready = ~req_valid | ~is_mem | req_ale | req_kill |
                     (data_sram_req & data_sram_addr_ok);

  assign head      = ent_q[dlv_q];
  assign head_live = (count_q != '0) & head.done;

  load_ext_unit u_ext (
    .size_i     (head.size),
    .unsigned_i (head.uns),
    .addr_i     (head.addr),
    .rdata_i    (head.rdata),
    .data_o     (ext_data)
  );

  assign resp_valid    = head_live & ~head.cancelled & ~flush;
  assign resp_is_store = ~head.is_load;
  assign resp_rdata    = head.is_load ? ext_data : 32'h0;

  assign alloc  = data_sram_req & data_sram_addr_ok;
  assign cpl    = data_sram_data_ok & (pend_q != '0);
  // Cancelled heads drain without a handshake.
  assign retire = (resp_valid & resp_ready) |
                  (head_live & head.cancelled);

  assign busy      = (count_q != '0);
  assign proto_err = perr_q;

  always_comb begin
    ent_d   = ent_q;
    alloc_d = alloc_q;
    ret_d   = ret_q;
    dlv_d   = dlv_q;
    perr_d  = perr_q | (data_sram_data_ok & (pend_q == '0));
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].cancelled = 1'b1;
    end
    if (cpl) begin
      ent_d[ret_q].done  = 1'b1;
      ent_d[ret_q].rdata = data_sram_rdata;
      ret_d = inc(ret_q);
    end
    if (alloc) begin
      ent_d[alloc_q] = '{
        is_load:   req_load,
        size:      req_size,
        uns:       req_unsigned,
        addr:      req_addr[1:0],
        done:      1'b0,
        cancelled: 1'b0,
        rdata:     32'h0
      };
      alloc_d = inc(alloc_q);
    end
    if (retire) dlv_d = inc(dlv_q);
    count_d = count_q + CW'(alloc) - CW'(retire);
    pend_d  = pend_q + CW'(alloc) - CW'(cpl);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      alloc_q <= '0;
      ret_q   <= '0;
      dlv_q   <= '0;
      count_q <= '0;
      pend_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      alloc_q <= alloc_d;
      ret_q   <= ret_d;
      dlv_q   <= dlv_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_mem_req_tracker.sv
// Directed bench for mem_req_tracker; a negedge monitor checks
// every delivered response against a queue of expected results.
module tb_mem_req_tracker;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_load, req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic        req_kill;
  logic        req_ready, req_ale;
  logic        flush;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        resp_valid, resp_ready, resp_is_store;
  logic [31:0] resp_rdata;
  logic        busy, proto_err;

  always #5 clk = ~clk;

  mem_req_tracker #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_load(req_load),
    .req_store(req_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_kill(req_kill),
    .req_ready(req_ready), .req_ale(req_ale), .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_is_store(resp_is_store), .resp_rdata(resp_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  typedef struct {
    logic        st;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vec  = 0;
  int   miss = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    vec++;
    if (act !== want) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      vec++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL resp_unexpected: got rdata %h st %b want none",
                 resp_rdata, resp_is_store);
      end else begin
        e = exp_q.pop_front();
        if (resp_is_store !== e.st || resp_rdata !== e.d) begin
          miss++;
          $display("FAIL resp: got st %b rdata %h want st %b rdata %h",
                   resp_is_store, resp_rdata, e.st, e.d);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req_valid         = 1'b0;
    req_load          = 1'b0;
    req_store         = 1'b0;
    req_kill          = 1'b0;
    flush             = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic drive(input logic ld, input logic st,
                       input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_load     = ld;
    req_store    = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  task automatic single(input string nm, input logic st,
                        input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [31:0] rexp,
                        input logic [3:0] strb, input logic [31:0] wexp);
    tick;
    drive(~st, st, sz, un, a, wd);
    data_sram_addr_ok = 1'b1;
    exp_q.push_back('{st, rexp});
    #1;
    chk({nm, "_req"}, 32'(data_sram_req), 32'd1);
    chk({nm, "_wr"}, 32'(data_sram_wr), 32'(st));
    chk({nm, "_size"}, 32'(data_sram_size), 32'(sz));
    chk({nm, "_wstrb"}, 32'(data_sram_wstrb), 32'(strb));
    chk({nm, "_wdata"}, data_sram_wdata, wexp);
    chk({nm, "_addr"}, data_sram_addr, a);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    tick;
    idle;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    #1;
    chk({nm, "_early"}, 32'(resp_valid), 32'd0);
    tick;
    idle;
    #1;
    chk({nm, "_valid"}, 32'(resp_valid), 32'd1);
    tick;
    #1;
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    idle;
    req_size        = SZ_W;
    req_unsigned    = 1'b0;
    req_addr        = '0;
    req_wdata       = '0;
    data_sram_rdata = '0;
    resp_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_req", 32'(data_sram_req), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_perr", 32'(proto_err), 32'd0);

    single("lb", 1'b0, SZ_B, 1'b0, 32'h1003, 32'h0,
           32'h80123456, 32'hFFFFFF80, 4'b0000, 32'h0);
    single("lbu", 1'b0, SZ_B, 1'b1, 32'h1003, 32'h0,
           32'h80123456, 32'h00000080, 4'b0000, 32'h0);
    single("sh", 1'b1, SZ_H, 1'b0, 32'h2002, 32'h0000ABCD,
           32'hDEADBEEF, 32'h0, 4'b1100, 32'hABCDABCD);
    single("sb", 1'b1, SZ_B, 1'b0, 32'h2001, 32'h123456EF,
           32'h0, 32'h0, 4'b0010, 32'hEFEFEFEF);

    // full tracker stalls the third load
    tick;
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
    data_sram_addr_ok = 1'b1;
    exp_q.push_back('{1'b0, 32'h11111111});
    tick;
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h104, 32'h0);
    exp_q.push_back('{1'b0, 32'h22222222});
    tick;
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h108, 32'h0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h11111111;
    #1;
    chk("full_req", 32'(data_sram_req), 32'd0);
    chk("full_ready", 32'(req_ready), 32'd0);
    tick;
    data_sram_data_ok = 1'b0;
    #1;
    chk("full_retire_req", 32'(data_sram_req), 32'd0);
    chk("full_retire_valid", 32'(resp_valid), 32'd1);
    tick;
    #1;
    chk("reissue_req", 32'(data_sram_req), 32'd1);
    chk("reissue_ready", 32'(req_ready), 32'd1);
    exp_q.push_back('{1'b0, 32'h33333333});
    tick;
    idle;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h22222222;
    tick;
    data_sram_rdata   = 32'h33333333;
    tick;
    idle;
    tick;
    #1;
    chk("full_drained", 32'(busy), 32'd0);

    // misaligned and killed ops pass without a bus request
    tick;
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h3002, 32'h0);
    data_sram_addr_ok = 1'b1;
    #1;
    chk("ale_flag", 32'(req_ale), 32'd1);
    chk("ale_req", 32'(data_sram_req), 32'd0);
    chk("ale_ready", 32'(req_ready), 32'd1);
    tick;
    drive(1'b1, 1'b0, SZ_H, 1'b0, 32'h3001, 32'h0);
    #1;
    chk("ale_half", 32'(req_ale), 32'd1);
    tick;
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h3000, 32'h0);
    req_kill = 1'b1;
    #1;
    chk("kill_req", 32'(data_sram_req), 32'd0);
    chk("kill_ready", 32'(req_ready), 32'd1);
    tick;
    idle;
    #1;
    chk("ale_busy", 32'(busy), 32'd0);

    // flush with two loads in flight
    tick;
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h200, 32'h0);
    data_sram_addr_ok = 1'b1;
    tick;
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h204, 32'h0);
    tick;
    flush = 1'b1;
    #1;
    chk("flush_req", 32'(data_sram_req), 32'd0);
    tick;
    idle;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAAAA5555;
    #1;
    chk("flush_v0", 32'(resp_valid), 32'd0);
    tick;
    #1;
    chk("flush_v1", 32'(resp_valid), 32'd0);
    tick;
    idle;
    #1;
    chk("flush_v2", 32'(resp_valid), 32'd0);
    tick;
    #1;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_perr", 32'(proto_err), 32'd0);

    // backpressure holds the head response stable
    resp_ready = 1'b0;
    tick;
    drive(1'b1, 1'b0, SZ_B, 1'b0, 32'h11, 32'h0);
    data_sram_addr_ok = 1'b1;
    exp_q.push_back('{1'b0, 32'h0000007F});
    tick;
    drive(1'b1, 1'b0, SZ_H, 1'b1, 32'h22, 32'h0);
    exp_q.push_back('{1'b0, 32'h0000BEEF});
    tick;
    idle;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h00007F00;
    tick;
    data_sram_rdata   = 32'hBEEF0000;
    for (int i = 0; i < 5; i++) begin
      tick;
      idle;
      drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h40, 32'h0);
      data_sram_addr_ok = 1'b1;
      #1;
      chk("bp_req", 32'(data_sram_req), 32'd0);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, 32'h0000007F);
    end
    tick;
    idle;
    resp_ready = 1'b1;
    #1;
    chk("bp_rel0", 32'(resp_valid), 32'd1);
    tick;
    #1;
    chk("bp_rel1", 32'(resp_valid), 32'd1);
    tick;
    #1;
    chk("bp_done_valid", 32'(resp_valid), 32'd0);
    chk("bp_done_busy", 32'(busy), 32'd0);

    // stray data_ok, then reset mid-operation
    tick;
    data_sram_data_ok = 1'b1;
    tick;
    idle;
    #1;
    chk("perr_set", 32'(proto_err), 32'd1);
    tick;
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h50, 32'h0);
    data_sram_addr_ok = 1'b1;
    tick;
    idle;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_perr", 32'(proto_err), 32'd0);
    chk("rst_mid_valid", 32'(resp_valid), 32'd0);
    tick;
    data_sram_data_ok = 1'b1;
    tick;
    idle;
    #1;
    chk("rst_perr_set", 32'(proto_err), 32'd1);

    tick;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/mem_req_tracker.md
Name: mem_req_tracker

Overview:
- Parametrised memory-request unit for the EXE/MEM boundary of the LoongArch pipeline.
- Issues loads and stores on the sram-like data interface (req/addr_ok/data_ok).
- Tracks up to DEPTH in-flight requests in order, and returns sign/zero-extended load data and store completions to the pipeline through a valid/ready response port.
- Cancels in-flight work on a pipeline flush. Unlike the single-outstanding EXE issue logic, it supports several outstanding requests, response backpressure and silent retirement of cancelled requests.

Parameters:
- DEPTH, 2, maximum outstanding requests (power of two, 1..8)
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  EXE holds a valid instruction
- req_load  in  1  instruction is a load
- req_store  in  1  instruction is a store
- req_size  in  2  0 = byte, 1 = half, 2 = word
- req_unsigned  in  1  zero-extend load result
- req_addr  in  ADDR_W  effective address
- req_wdata  in  32  store source register value
- req_kill  in  1  instruction carries an exception (EXE/MEM/WB); suppress issue
- req_ready  out  1  EXE may advance this cycle
- req_ale  out  1  address misaligned for req_size (combinational, gated by req_valid and a memory op)
- flush  in  1  WB exception/ertn; cancel everything
- data_sram_req  out  1  request
- data_sram_wr  out  1  write
- data_sram_size  out  2  access size
- data_sram_wstrb  out  4  byte enables
- data_sram_addr  out  ADDR_W  address
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  oldest accepted request complete
- data_sram_rdata  in  32  read data
- resp_valid  out  1  oldest live request complete
- resp_ready  in  1  MEM/WB accepts response
- resp_is_store  out  1  response is a store completion
- resp_rdata  out  32  extended load data; 0 for stores
- busy  out  1  any entry occupied
- proto_err  out  1  sticky: data_ok seen with no outstanding entry

Behaviour:
- Reset values: all entries free, count 0; data_sram_req, resp_valid, busy and proto_err 0.
- Entry fields: is_load, size, unsigned, addr[1:0], done, cancelled, rdata[31:0].
- Pointers: alloc_ptr (advances on addr_ok), ret_ptr (advances on data_ok), dlv_ptr (advances on retire). count = occupied entries. All pointers wrap modulo DEPTH.
- Misalignment: req_ale = word with addr[1:0] != 0, or half with addr[0] = 1.
- Issue condition:
  - data_sram_req = req_valid & (req_load | req_store) & ~req_ale & ~req_kill & ~flush & (count < DEPTH).
  - data_sram_wr = data_sram_req & req_store.
- Other request outputs are combinational from req_*:
  - wstrb: byte = one-hot of addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111; 0 for loads.
  - wdata: byte replicated ×4, half replicated ×2.
  - Address passed through unchanged.
- req_ready = ~req_valid | ~(req_load | req_store) | req_ale | req_kill | (data_sram_req & data_sram_addr_ok). Misaligned and killed operations pass through with no bus request.
- Allocation: when data_sram_req & addr_ok, the entry at alloc_ptr is written with done = 0, cancelled = 0, and count increments.
- Completion: on data_ok, the entry at ret_ptr gets done = 1 and rdata = data_sram_rdata. If count == 0 or every occupied entry is already done, set proto_err and change nothing else.
- Delivery:
  - resp_valid = entry[dlv_ptr] occupied & done & ~cancelled.
  - Data is extended from the stored addr, size and unsigned fields.
  - Earliest response is the cycle after data_ok.
  - Retire on resp_valid & resp_ready. Hold resp outputs stable while not ready.
- Cancelled retire: an entry at dlv_ptr that is done & cancelled retires silently (at most one retire per cycle) with no resp_valid.
- Flush:
  - Every occupied entry is marked cancelled that cycle.
  - Issue is suppressed that cycle, and resp_valid is forced to 0 that cycle.
  - Cancelled entries still await their data_ok, because the bus owes them.
  - A data_ok in the flush cycle lands on its entry, which is then dropped.
- Simultaneous events: allocate, complete and retire may all occur in one cycle; count updates by (+alloc − retire).
- busy = (count != 0). Full: no issue while count == DEPTH, even if retire happens the same cycle. This avoids a combinational path from resp_ready to data_sram_req.
- Reset mid-operation clears all state; data_ok after reset with count 0 sets proto_err.

Decomposition:
- Shared package mem_pkg:
  - Size encodings SZ_B/SZ_H/SZ_W.
  - Entry struct.
  - Functions wstrb_gen, wdata_rep, load_ext.
- Sub-module load_ext_unit (combinational extension by size/unsigned/addr[1:0]), reused by the MEM stage.

Test Plan:
- Load byte, signed, addr 0x1003, rdata 0x80123456 -> resp_valid the cycle after data_ok, resp_rdata 0xFFFFFF80. Same with unsigned -> 0x00000080.
- Store half, addr 0x2002, wdata 0x0000ABCD -> data_sram_wr = 1, wstrb 4'b1100, data_sram_wdata 0xABCDABCD, size 1. data_ok -> resp_is_store = 1.
- DEPTH = 2, two loads accepted with data_ok withheld -> third load sees data_sram_req = 0 and req_ready = 0. First data_ok plus retire -> third load issues the next cycle.
- Word load at addr 0x3002 -> req_ale = 1, data_sram_req = 0, req_ready = 1, count unchanged.
- Two loads outstanding, flush pulse, then two data_ok -> no resp_valid, count returns to 0, busy = 0, proto_err = 0.
- resp_ready held low for 5 cycles with 2 completed loads -> resp_rdata stable, no issue beyond DEPTH. Release -> responses delivered in order, one per cycle.
